// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin arbiter slice.
//   MAX_NUM_REQ : largest requester count the arbiter supports
//   clog2_safe  : ceil(log2(n)), never less than 1, used to size/check IDX_W
//   arb_idx_t   : index type wide enough for MAX_NUM_REQ requesters
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int MAX_NUM_REQ = 256;

    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef logic [clog2_safe(MAX_NUM_REQ)-1:0] arb_idx_t;

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating priority encoder: returns the first set request at
// or above i_start, wrapping from NUM_REQ-1 back to 0.
//   i_req   : request vector, bit i = requester i
//   i_start : index with highest priority (0..NUM_REQ-1)
//   o_any   : at least one request is set
//   o_idx   : winning index (0 when o_any = 0)
// ---------------------------------------------------------------------------
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx
);

    logic [NUM_REQ-1:0]   w_mask;
    logic [2*NUM_REQ-1:0] w_dbl;

    // Lower half keeps only requests at/above start; upper half is the full
    // vector, so the lowest set bit of the concatenation is the wrapped winner.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (i >= int'(i_start));
        end
    end

    assign w_dbl = {i_req, i_req & w_mask};

    // Scan downward so the lowest set bit is the last one assigned.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                o_any = 1'b1;
                o_idx = (i >= NUM_REQ) ? IDX_W'(i - NUM_REQ) : IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_bin_grant.sv
// ---------------------------------------------------------------------------
// rr_arbiter_bin_grant
// Round-robin arbiter presenting a registered binary grant index on a
// valid/ready handshake. The grant holds until accepted; priority rotates
// to the index after the accepted winner on every acceptance.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : level requests, bit i = requester i
//   gnt_valid : gnt_idx holds a valid winner
//   gnt_ready : consumer accepts the grant this cycle
//   gnt_idx   : binary index of the winning requester
//   gnt_fire  : gnt_valid && gnt_ready (requester-side acknowledge)
// ---------------------------------------------------------------------------
module rr_arbiter_bin_grant
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               gnt_valid,
    input  logic               gnt_ready,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_fire
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
        $error("rr_arbiter_bin_grant: NUM_REQ out of range 2..256");
    end
    if (IDX_W != clog2_safe(NUM_REQ)) begin : g_bad_idx_w
        $error("rr_arbiter_bin_grant: IDX_W must equal clog2(NUM_REQ)");
    end

    logic               r_gnt_valid;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [IDX_W-1:0]   r_ptr;

    logic               w_fire;
    logic [IDX_W-1:0]   w_next_idx;
    logic [IDX_W-1:0]   w_start;
    logic [NUM_REQ-1:0] w_fire_mask;
    logic [NUM_REQ-1:0] w_eff_req;
    logic               w_any;
    logic [IDX_W-1:0]   w_pick;

    assign w_fire = r_gnt_valid & gnt_ready;

    // Explicit wrap so non-power-of-two NUM_REQ never yields an index >= NUM_REQ.
    assign w_next_idx = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

    // On acceptance the winner is excluded so a lone persistent requester
    // cannot be granted on two consecutive edges.
    assign w_start     = w_fire ? w_next_idx : r_ptr;
    assign w_fire_mask = w_fire ? (NUM_REQ'(1) << r_gnt_idx) : '0;
    assign w_eff_req   = req & ~w_fire_mask;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (w_eff_req),
        .i_start (w_start),
        .o_any   (w_any),
        .o_idx   (w_pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
            r_ptr       <= '0;
        end else if (w_fire) begin
            r_ptr       <= w_next_idx;
            r_gnt_valid <= w_any;
            if (w_any) begin
                r_gnt_idx <= w_pick;
            end
        end else if (!r_gnt_valid && w_any) begin
            r_gnt_valid <= 1'b1;
            r_gnt_idx   <= w_pick;
        end
    end

    assign gnt_valid = r_gnt_valid;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_fire  = w_fire;

endmodule
